// File: rtl/store_pkg.sv
// Shared types for the memory-stage store path: store size encoding and FSM states.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } st_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/store_unit_if.sv
// Data-memory write channel (request + write response) between store_unit and memory.
interface store_unit_if #(
  parameter int WordSize = 32,
  parameter int AddrSize = 32
);
  localparam int L = WordSize / 8;

  logic                mem_wvalid;
  logic                mem_wready;
  logic [AddrSize-1:0] mem_waddr;
  logic [WordSize-1:0] mem_wdata;
  logic [L-1:0]        mem_wstrb;
  logic                mem_bvalid;
  logic                mem_berr;

  modport master (
    output mem_wvalid, mem_waddr, mem_wdata, mem_wstrb,
    input  mem_wready, mem_bvalid, mem_berr
  );

  modport slave (
    input  mem_wvalid, mem_waddr, mem_wdata, mem_wstrb,
    output mem_wready, mem_bvalid, mem_berr
  );
endinterface

// File: rtl/store_align.sv
// Combinational lane placement: masks store data to its size, shifts it onto the
// byte lanes selected by the address offset, and flags misaligned/illegal sizes.
module store_align
  import store_pkg::*;
#(
  parameter int WordSize = 32,
  parameter int L        = WordSize / 8,
  parameter int OW       = $clog2(L)
) (
  input  st_size_e            size,
  input  logic [OW-1:0]       offset,
  input  logic [WordSize-1:0] data,
  output logic [WordSize-1:0] wdata,
  output logic [L-1:0]        wstrb,
  output logic                misalign
);

  logic [WordSize-1:0] mask;
  logic [L-1:0]        strb_base;

  always_comb begin
    mask      = '0;
    strb_base = '0;
    misalign  = 1'b0;
    case (size)
      SZ_BYTE: begin
        mask      = WordSize'(32'h0000_00FF);
        strb_base = L'(4'b0001);
      end
      SZ_HALF: begin
        mask      = WordSize'(32'h0000_FFFF);
        strb_base = L'(4'b0011);
        misalign  = offset[0];
      end
      SZ_WORD: begin
        mask      = WordSize'(32'hFFFF_FFFF);
        strb_base = L'(4'b1111);
        misalign  = (offset[1:0] != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end

  assign wdata = (data & mask) << {offset, 3'b000};
  assign wstrb = strb_base << offset;

endmodule

// File: rtl/store_unit.sv
// Memory-stage store unit: accepts one store per handshake, drives the write channel,
// waits for the write response and holds the pipeline until the store retires.
module store_unit
  import store_pkg::*;
#(
  parameter int WordSize = 32,
  parameter int AddrSize = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                st_valid,
  input  logic [1:0]          st_size,
  input  logic [AddrSize-1:0] st_addr,
  input  logic [WordSize-1:0] st_data,
  output logic                st_ready,
  output logic                stall,
  output logic                st_done,
  output logic                st_err,
  store_unit_if.master        mem
);

  localparam int L  = WordSize / 8;
  localparam int OW = $clog2(L);

  state_e              state, state_n;
  logic [WordSize-1:0] al_wdata;
  logic [L-1:0]        al_wstrb;
  logic                al_misalign;
  logic                accept;
  logic                done_n, err_n;

  store_align #(
    .WordSize (WordSize)
  ) u_align (
    .size     (st_size_e'(st_size)),
    .offset   (st_addr[OW-1:0]),
    .data     (st_data),
    .wdata    (al_wdata),
    .wstrb    (al_wstrb),
    .misalign (al_misalign)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (st_valid) begin
          if (al_misalign) begin
            err_n = 1'b1;
          end else begin
            accept  = 1'b1;
            state_n = REQ;
          end
        end
      end
      REQ: begin
        if (mem.mem_wready) state_n = RESP;
      end
      RESP: begin
        if (mem.mem_bvalid) begin
          done_n  = !mem.mem_berr;
          err_n   = mem.mem_berr;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Payload is captured only on accept, so it stays frozen across wready back-pressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem.mem_waddr <= '0;
      mem.mem_wdata <= '0;
      mem.mem_wstrb <= '0;
      st_done       <= 1'b0;
      st_err        <= 1'b0;
    end else begin
      st_done <= done_n;
      st_err  <= err_n;
      if (accept) begin
        mem.mem_waddr <= {st_addr[AddrSize-1:OW], {OW{1'b0}}};
        mem.mem_wdata <= al_wdata;
        mem.mem_wstrb <= al_wstrb;
      end
    end
  end

  assign mem.mem_wvalid = (state == REQ);
  assign stall          = (state != IDLE);
  assign st_ready       = (state == IDLE);

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: lane placement, alignment rejects, back-pressure,
// bus errors and asynchronous reset mid-transaction.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        st_valid;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready, stall, st_done, st_err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  store_unit_if #(.WordSize(32), .AddrSize(32)) mem_bus ();

  store_unit #(.WordSize(32), .AddrSize(32)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .st_valid (st_valid),
    .st_size  (st_size),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_ready (st_ready),
    .stall    (stall),
    .st_done  (st_done),
    .st_err   (st_err),
    .mem      (mem_bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    st_valid = 1'b1;
    st_size  = size;
    st_addr  = addr;
    st_data  = data;
  endtask

  // Zero-wait store: accept edge N, wvalid in N+1, bvalid in N+2, st_done in N+3.
  task automatic run_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] e_addr,
                           input logic [31:0] e_data, input logic [3:0] e_strb);
    issue(size, addr, data);
    mem_bus.mem_wready = 1'b1;
    chk({tag, "_ready"}, st_ready, 1'b1);
    tick();
    st_valid = 1'b0;
    chk({tag, "_wvalid"}, mem_bus.mem_wvalid, 1'b1);
    chk({tag, "_waddr"}, mem_bus.mem_waddr, e_addr);
    chk({tag, "_wdata"}, mem_bus.mem_wdata, e_data);
    chk({tag, "_wstrb"}, mem_bus.mem_wstrb, e_strb);
    chk({tag, "_stall"}, stall, 1'b1);
    tick();
    mem_bus.mem_wready = 1'b0;
    mem_bus.mem_bvalid = 1'b1;
    chk({tag, "_resp_wvalid"}, mem_bus.mem_wvalid, 1'b0);
    chk({tag, "_resp_done"}, st_done, 1'b0);
    tick();
    mem_bus.mem_bvalid = 1'b0;
    chk({tag, "_done"}, st_done, 1'b1);
    chk({tag, "_noerr"}, st_err, 1'b0);
    chk({tag, "_idle"}, {stall, st_ready}, 2'b01);
  endtask

  initial begin
    rstn = 1'b0;
    st_valid = 1'b0;
    st_size = 2'd0;
    st_addr = '0;
    st_data = '0;
    mem_bus.mem_wready = 1'b0;
    mem_bus.mem_bvalid = 1'b0;
    mem_bus.mem_berr   = 1'b0;
    tick();
    tick();
    chk("rst_ready", st_ready, 1'b1);
    chk("rst_stall", stall, 1'b0);
    chk("rst_pulses", {st_done, st_err}, 2'b00);
    chk("rst_wvalid", mem_bus.mem_wvalid, 1'b0);
    chk("rst_payload", {mem_bus.mem_waddr, mem_bus.mem_wdata}, 64'h0);
    chk("rst_wstrb", mem_bus.mem_wstrb, 4'h0);
    rstn = 1'b1;
    tick();

    run_store("byte1003", 2'd0, 32'h0000_1003, 32'hAABB_CCDD, 32'h0000_1000, 32'hDD00_0000, 4'b1000);
    tick();
    chk("byte1003_pulse_len", st_done, 1'b0);

    run_store("half2002", 2'd1, 32'h0000_2002, 32'h0000_1234, 32'h0000_2000, 32'h1234_0000, 4'b1100);
    run_store("byte0001", 2'd0, 32'h0000_0001, 32'h0000_005A, 32'h0000_0000, 32'h0000_5A00, 4'b0010);

    // Misaligned half: error pulse in N+1 only, no bus request.
    issue(2'd1, 32'h0000_2001, 32'h0000_1234);
    tick();
    st_valid = 1'b0;
    chk("mis_err", st_err, 1'b1);
    chk("mis_wvalid", mem_bus.mem_wvalid, 1'b0);
    chk("mis_ready", {st_ready, stall}, 2'b10);
    tick();
    chk("mis_err_len", st_err, 1'b0);
    chk("mis_wvalid2", mem_bus.mem_wvalid, 1'b0);

    // Misaligned word.
    issue(2'd2, 32'h0000_0042, 32'h0000_0000);
    tick();
    st_valid = 1'b0;
    chk("misw_err", {st_err, mem_bus.mem_wvalid}, 2'b10);

    // Word store with wready low for 4 cycles.
    issue(2'd2, 32'h0000_0040, 32'hCAFE_F00D);
    mem_bus.mem_wready = 1'b0;
    tick();
    st_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_wvalid", mem_bus.mem_wvalid, 1'b1);
      chk("bp_waddr", mem_bus.mem_waddr, 32'h0000_0040);
      chk("bp_wdata", mem_bus.mem_wdata, 32'hCAFE_F00D);
      chk("bp_wstrb", mem_bus.mem_wstrb, 4'b1111);
      chk("bp_stall", {stall, st_ready}, 2'b10);
      if (i == 4) mem_bus.mem_wready = 1'b1;
      // bvalid during REQ must be ignored.
      mem_bus.mem_bvalid = (i == 1);
      tick();
    end
    mem_bus.mem_wready = 1'b0;
    mem_bus.mem_bvalid = 1'b0;
    chk("bp_resp", {mem_bus.mem_wvalid, stall, st_done}, 3'b010);
    tick();
    chk("bp_resp_wait", {stall, st_done}, 2'b10);
    mem_bus.mem_bvalid = 1'b1;
    tick();
    mem_bus.mem_bvalid = 1'b0;
    chk("bp_done", {st_done, st_err, stall}, 3'b100);

    // Bus error response.
    issue(2'd2, 32'h0000_0080, 32'h0BAD_0BAD);
    mem_bus.mem_wready = 1'b1;
    tick();
    st_valid = 1'b0;
    tick();
    mem_bus.mem_wready = 1'b0;
    mem_bus.mem_bvalid = 1'b1;
    mem_bus.mem_berr   = 1'b1;
    tick();
    mem_bus.mem_bvalid = 1'b0;
    mem_bus.mem_berr   = 1'b0;
    chk("berr_pulse", {st_err, st_done}, 2'b10);
    chk("berr_idle", {st_ready, stall}, 2'b10);
    tick();
    chk("berr_len", {st_err, st_done}, 2'b00);

    // Illegal size then an immediate legal word store.
    issue(2'd3, 32'h0000_0100, 32'hFFFF_FFFF);
    tick();
    chk("ill_err", {st_err, mem_bus.mem_wvalid, st_ready}, 3'b101);
    run_store("after_ill", 2'd2, 32'h0000_0104, 32'h1122_3344, 32'h0000_0104, 32'h1122_3344, 4'b1111);

    // Asynchronous reset while waiting for the response.
    issue(2'd0, 32'h0000_0202, 32'h0000_00EE);
    mem_bus.mem_wready = 1'b1;
    tick();
    st_valid = 1'b0;
    tick();
    mem_bus.mem_wready = 1'b0;
    chk("rr_in_resp", {stall, mem_bus.mem_wvalid}, 2'b10);
    rstn = 1'b0;
    #1;
    chk("rr_stall", {stall, st_ready}, 2'b01);
    chk("rr_wvalid", mem_bus.mem_wvalid, 1'b0);
    chk("rr_payload", {mem_bus.mem_waddr, mem_bus.mem_wdata}, 64'h0);
    chk("rr_wstrb", mem_bus.mem_wstrb, 4'h0);
    tick();
    rstn = 1'b1;
    mem_bus.mem_bvalid = 1'b1;
    tick();
    mem_bus.mem_bvalid = 1'b0;
    chk("rr_no_pulse", {st_done, st_err}, 2'b00);
    chk("rr_idle", {st_ready, stall}, 2'b10);
    tick();
    chk("rr_no_pulse2", {st_done, st_err}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
